seq_player: RTL and testbench
=============================

Name: seq_player

Overview:
- Reader side of the FPGA sequence register: plays the stored 64-bit Genius sequence back on the four game LEDs, one nibble per step.
- Plays steps 0..round at a slow tick rate, then pulses done. The control FSM uses done to open the user-input phase.
- Sits between the FPGA sequence register / round counter and the leds output. Tick enables come from the clock divider.

Parameters:
- NSTEPS, 16, max steps held in seq (seq width = 4*NSTEPS).
- ON_TICKS, 2, ticks each step is lit (>=1).
- OFF_TICKS, 1, dark ticks after each step (>=1).

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- R  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to play; honoured only in IDLE.
- tick  input  1  one-cycle enable from the clock divider; all step timing counts ticks, not clocks.
- round  input  4  index of last step to play (0 -> 1 step, 15 -> 16 steps).
- seq  input  64  step i is seq[4i+3:4i]. The caller aligns step 0 at [3:0].
- leds  output  4  current step pattern while lit, 0 otherwise.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the last OFF phase ends.
- step  output  4  index of step being played; 0 when idle.

Behaviour:
- Reset (R=1 at clk edge): state=IDLE; leds=0, busy=0, done=0, step=0; tick counter=0; snapshots cleared. R has priority over every other input, in every state.
- States: IDLE, ON, OFF.
- IDLE, start=1:
  - Latch seq into seq_q and round into last_q (snapshot; later input changes are ignored until the next start).
  - step=0, cnt=0, next state ON.
  - A tick in the same cycle is ignored.
- ON:
  - leds = seq_q[4*step+3:4*step], registered. leds shows nibble 0 in the first cycle after start.
  - On each tick, cnt++. When cnt would reach ON_TICKS: cnt=0, leds=0, go to OFF.
- OFF:
  - leds=0. On each tick, cnt++.
  - When cnt would reach OFF_TICKS and step==last_q: done=1 for one cycle, busy=0, step=0, go to IDLE (all in the same cycle).
  - Otherwise at that point: step++, cnt=0, go to ON.
- busy = (state != IDLE), registered alongside state.
- start while busy: ignored, no restart, no queueing. start in the same cycle done is asserted is also ignored: the FSM is not yet in IDLE.
- Nibble 0000: still occupies full ON+OFF time with leds dark. Nibbles that are not one-hot are driven as-is.
- round > NSTEPS-1 cannot occur with NSTEPS=16. For smaller NSTEPS, last_q is clamped to NSTEPS-1.
- No tick activity: the FSM holds state indefinitely. Clock counts between ticks are irrelevant.
- Total duration: (round+1)*(ON_TICKS+OFF_TICKS) ticks.

Optional Feature:
- Macro LEVEL_SPEED_EN.
- When defined:
  - Adds input port level (2 bits, from SETUP level field), sampled at start into level_q.
  - Effective on time = max(1, ON_TICKS >> level_q). Harder levels flash faster.
  - OFF time unchanged.
- When undefined: port absent; on time is ON_TICKS.

Test Plan:
- Reset, then idle with ticks toggling -> leds=0, busy=0, done=0, step=0 throughout.
- seq=...0000_0100_0010_0001 (steps 1,2,4), round=2, defaults, start -> leds sequence 1 (2 ticks), 0 (1), 2 (2), 0 (1), 4 (2), 0 (1); done pulses once after 9th tick; busy low same cycle.
- round=0, seq[3:0]=1000, start and tick in same cycle -> that tick not counted; leds=8 for the next 2 ticks, dark 1 tick, done; step stays 0.
- During playback, change seq and round and pulse start -> output unchanged from the original snapshot, no restart.
- Assert R during ON of step 1 -> next cycle leds=0, busy=0, step=0, no done. A new start then replays from step 0.
- With LEVEL_SPEED_EN, ON_TICKS=4, level=2, round=1 -> each step lit 1 tick; level=3 -> still 1 tick (floor); total 4 ticks.

Source files
------------

// File: rtl/seq_player.sv
// ---------------------------------------------------------------------------
// seq_player
//
// Plays a stored Genius sequence back on the four game LEDs, one nibble per
// step. Steps 0..round are each lit for ON_TICKS divider ticks and then held
// dark for OFF_TICKS ticks. A one-cycle done pulse follows the final dark
// phase, which lets the control FSM open the user-input phase.
//
// Optional feature macro: LEVEL_SPEED_EN
//   When defined, a 2-bit level port is sampled at start. The on time then
//   becomes max(1, ON_TICKS >> level), so harder levels flash faster. The
//   off time does not change.
//
// Parameters:
//   NSTEPS    - maximum number of steps held in seq (seq is 4*NSTEPS wide)
//   ON_TICKS  - ticks each step is lit (>= 1)
//   OFF_TICKS - dark ticks after each step (>= 1)
//
// Ports:
//   clk    in   system clock
//   R      in   synchronous reset, active-high, overrides everything
//   start  in   one-cycle play request, honoured only when idle
//   tick   in   one-cycle enable from the clock divider (timebase)
//   round  in   index of the last step to play
//   seq    in   step i lives at seq[4i+3:4i]
//   level  in   (LEVEL_SPEED_EN only) speed level, sampled at start
//   leds   out  current step pattern while lit, 0 otherwise
//   busy   out  high from the cycle after start until done
//   done   out  one-cycle pulse when the last dark phase ends
//   step   out  index of the step being played, 0 when idle
// ---------------------------------------------------------------------------
module seq_player #(
    parameter int NSTEPS    = 16,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  start,
    input  logic                  tick,
    input  logic [3:0]            round,
    input  logic [4*NSTEPS-1:0]   seq,
`ifdef LEVEL_SPEED_EN
    input  logic [1:0]            level,
`endif
    output logic [3:0]            leds,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            step
);

    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [CW:0] OFF_LIM  = (CW+1)'(OFF_TICKS);
    localparam logic [4:0]  LAST_MAX = 5'(NSTEPS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [CW:0]         cnt_inc;
    logic [CW:0]         on_lim;
    logic [3:0]          step_n;
    logic [3:0]          last_q, last_n;
    logic [3:0]          leds_n;
    logic [4*NSTEPS-1:0] seq_q, seq_n;
    logic                busy_n, done_n;

    // Selects nibble i of a sequence snapshot.
    function automatic logic [3:0] nibble(input logic [4*NSTEPS-1:0] s,
                                          input logic [3:0] i);
        return s[{i, 2'b00} +: 4];
    endfunction

`ifdef LEVEL_SPEED_EN
    logic [1:0] level_q, level_n;
    int         on_shift;

    // Faster flashing at higher levels, but never shorter than one tick.
    assign on_shift = ON_TICKS >> level_q;
    assign on_lim   = (on_shift < 1) ? (CW+1)'(1) : (CW+1)'(on_shift);
`else
    assign on_lim = (CW+1)'(ON_TICKS);
`endif

    assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);

    // State register plus the registered outputs and playback snapshots.
    always_ff @(posedge clk) begin
        if (R) begin
            state  <= IDLE;
            cnt    <= '0;
            step   <= '0;
            last_q <= '0;
            seq_q  <= '0;
            leds   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef LEVEL_SPEED_EN
            level_q <= '0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            step   <= step_n;
            last_q <= last_n;
            seq_q  <= seq_n;
            leds   <= leds_n;
            busy   <= busy_n;
            done   <= done_n;
`ifdef LEVEL_SPEED_EN
            level_q <= level_n;
`endif
        end
    end

    // Next-state logic. Outputs are computed one cycle early so that leds
    // already shows the new nibble in the first cycle of each lit phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = step;
        last_n  = last_q;
        seq_n   = seq_q;
        leds_n  = leds;
        done_n  = 1'b0;
`ifdef LEVEL_SPEED_EN
        level_n = level_q;
`endif
        case (state)
            IDLE: begin
                leds_n = '0;
                step_n = '0;
                // A tick arriving with start is deliberately not counted.
                if (start) begin
                    seq_n   = seq;
                    last_n  = ({1'b0, round} > LAST_MAX) ? LAST_MAX[3:0] : round;
                    cnt_n   = '0;
                    leds_n  = seq[3:0];
                    state_n = ON;
`ifdef LEVEL_SPEED_EN
                    level_n = level;
`endif
                end
            end
            ON: begin
                leds_n = nibble(seq_q, step);
                if (tick) begin
                    if (cnt_inc == on_lim) begin
                        cnt_n   = '0;
                        leds_n  = '0;
                        state_n = OFF;
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end
            OFF: begin
                leds_n = '0;
                if (tick) begin
                    if (cnt_inc == OFF_LIM) begin
                        cnt_n = '0;
                        if (step == last_q) begin
                            done_n  = 1'b1;
                            step_n  = '0;
                            state_n = IDLE;
                        end else begin
                            step_n  = step + 4'd1;
                            leds_n  = nibble(seq_q, step + 4'd1);
                            state_n = ON;
                        end
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                leds_n  = '0;
                step_n  = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_seq_player.sv
// ---------------------------------------------------------------------------
// tb_seq_player
//
// Directed testbench for seq_player with default parameters. Each step drives
// inputs one time unit after a rising edge and checks the registered outputs
// one time unit after the following rising edge. Expected values are worked
// out by hand from the playback timing (2 lit ticks, 1 dark tick per step).
// ---------------------------------------------------------------------------
module tb_seq_player;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  round = '0;
    logic [63:0] seq = '0;
`ifdef LEVEL_SPEED_EN
    logic [1:0]  level = '0;
`endif
    logic [3:0]  leds;
    logic        busy;
    logic        done;
    logic [3:0]  step;

    int assertCount = 0;
    int failCount   = 0;

    // Expected results for the three-step playback, one entry per tick.
    logic [3:0] expLedsTab [9] = '{4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
    logic [3:0] expStepTab [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd0};

    seq_player dut (
        .clk   (clk),
        .R     (R),
        .start (start),
        .tick  (tick),
        .round (round),
        .seq   (seq),
`ifdef LEVEL_SPEED_EN
        .level (level),
`endif
        .leds  (leds),
        .busy  (busy),
        .done  (done),
        .step  (step)
    );

    always #5 clk = ~clk;

    // Drives one clock cycle with the given strobes, then drops them.
    task automatic applyStimulus(input logic tickIn, input logic startIn, input logic resetIn);
        tick  = tickIn;
        start = startIn;
        R     = resetIn;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        R     = 1'b0;
    endtask

    // Compares all outputs at once against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] expLeds,
                               input logic expBusy, input logic expDone,
                               input logic [3:0] expStep);
        assertCount++;
        assert ({leds, busy, done, step} === {expLeds, expBusy, expDone, expStep})
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed leds=%h busy=%b done=%b step=%0d, expected leds=%h busy=%b done=%b step=%0d",
                   tag, leds, busy, done, step, expLeds, expBusy, expDone, expStep);
        end
    endtask

    initial begin
        // Reset and idle with ticks toggling
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset", 4'h0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("idle_tick%0d", i), 4'h0, 1'b0, 1'b0, 4'd0);
        end

        // Three-step playback with a mid-play restart attempt
        seq   = 64'h0000_0000_0000_0421;
        round = 4'd2;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("play_start", 4'h1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("play_no_tick", 4'h1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                seq   = 64'hFFFF_FFFF_FFFF_FFFF;
                round = 4'd0;
                applyStimulus(1'b0, 1'b1, 1'b0);
                checkOutput("restart_ignored", 4'h2, 1'b1, 1'b0, 4'd1);
            end
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("play_tick%0d", i + 1), expLedsTab[i],
                        (i != 8), (i == 8), expStepTab[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("play_after_done", 4'h0, 1'b0, 1'b0, 4'd0);

        // Single step, start together with tick, start during done
        seq   = 64'h0000_0000_0000_0008;
        round = 4'd0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("single_start", 4'h8, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("single_tick1", 4'h8, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("single_tick2", 4'h0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("single_done", 4'h0, 1'b0, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_at_done_ignored", 4'h0, 1'b0, 1'b0, 4'd0);

        // Reset during the lit phase of step 1, then replay from step 0
        seq   = 64'h0000_0000_0000_0021;
        round = 4'd1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset_step1", 4'h2, 1'b1, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("mid_reset", 4'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_idle", 4'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("replay_start", 4'h1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("replay_last_dark", 4'h0, 1'b1, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("replay_done", 4'h0, 1'b0, 1'b1, 4'd0);

        // Dark nibble still takes full time, non-one-hot nibble shown as-is
        seq   = 64'h0000_0000_0000_0050;
        round = 4'd1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("dark_start", 4'h0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("dark_off", 4'h0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("dark_next_step", 4'h5, 1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("dark_done", 4'h0, 1'b0, 1'b1, 4'd0);

`ifdef LEVEL_SPEED_EN
        // Level 3 shortens the lit phase to one tick
        seq   = 64'h0000_0000_0000_0021;
        round = 4'd1;
        level = 2'd3;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lvl_start", 4'h1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lvl_off0", 4'h0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lvl_on1", 4'h2, 1'b1, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lvl_done", 4'h0, 1'b0, 1'b1, 4'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
